// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one load/store, completes it LATENCY cycles later
// with a single-cycle ready pulse, byte-lane writes and an address-range error flag.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        mem_ready_o,
    output logic        mem_err_o,
    output logic        busy_o
);

    localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CW   = $clog2(LATENCY + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Addresses below BASE_ADDR wrap to a huge 33-bit offset, so one compare covers both bounds.
    logic [32:0] off;
    logic        in_range;

    assign off      = {1'b0, mem_addr_i} - {1'b0, BASE_ADDR};
    assign in_range = (off < SPAN);

    logic          we_p0;
    logic [3:0]    be_p0;
    logic [31:0]   wd_p0;
    logic [AW-1:0] idx_p0;
    logic          ok_p0;
    logic          done;

    logic [31:0] mem [DEPTH_WORDS];

    assign done = (state == WAIT) && (cnt == '0);

    // ---- request capture (IDLE sample edge) ----
    always_ff @(posedge clk_i) begin
        if (state == IDLE && mem_req_i) begin
            we_p0  <= mem_we_i;
            be_p0  <= mem_be_i;
            wd_p0  <= mem_wd_i;
            idx_p0 <= off[AW+1:2];
            ok_p0  <= in_range;
        end
    end

    // ---- storage (completion edge); a coinciding reset cancels the write ----
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && we_p0 && ok_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_p0[b]) begin
                    mem[idx_p0][8*b +: 8] <= wd_p0[8*b +: 8];
                end
            end
        end
    end

    // ---- control and registered response ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            mem_rd_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        cnt    <= CW'(LATENCY - 1);
                        busy_o <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mem_ready_o <= 1'b1;
                        mem_err_o   <= !ok_p0;
                        if (!we_p0) begin
                            mem_rd_o <= ok_p0 ? mem[idx_p0] : 32'h0;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    // The requester still presents the finished request here, so it is not re-sampled.
                    mem_ready_o <= 1'b0;
                    mem_err_o   <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=1 and a LATENCY=3 instance driven with directed
// and random transactions, checked every cycle against a transaction-level model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(LAT0)) u_l1 (
        .clk_i(clk), .rst_i(rst[0]), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
        .mem_addr_i(addr[0]), .mem_wd_i(wd[0]), .mem_rd_o(rd[0]), .mem_ready_o(ready[0]),
        .mem_err_o(err[0]), .busy_o(busy[0]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(LAT1)) u_l3 (
        .clk_i(clk), .rst_i(rst[1]), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
        .mem_addr_i(addr[1]), .mem_wd_i(wd[1]), .mem_rd_o(rd[1]), .mem_ready_o(ready[1]),
        .mem_err_o(err[1]), .busy_o(busy[1]));

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d] cycle %0d: got %h, expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // Transaction-level model: a request is accepted when the responder is free, completes
    // LATENCY cycles later, and the responder is free again two cycles after completion.
    logic [31:0] m_mem  [2][DEPTH];
    bit          m_val  [2][DEPTH];
    bit          m_pend [2];
    bit          m_resp [2];
    int          m_due  [2];
    logic        m_we   [2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] e_rd   [2];
    bit          e_known[2];
    logic        e_ready[2];
    logic        e_err  [2];
    logic        e_busy [2];

    task automatic model_access(input int i);
        int idx;
        bit ok;
        idx = int'(m_addr[i][11:2]);
        ok  = (m_addr[i] < 32'(4 * DEPTH));
        e_err[i] = !ok;
        if (m_we[i]) begin
            if (ok) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[i][b]) m_mem[i][idx][8*b +: 8] = m_wd[i][8*b +: 8];
                if (m_be[i] == 4'hF) m_val[i][idx] = 1'b1;
            end
        end else if (ok) begin
            e_rd[i]    = m_mem[i][idx];
            e_known[i] = m_val[i][idx];
        end else begin
            e_rd[i]    = 32'h0;
            e_known[i] = 1'b1;
        end
    endtask

    task automatic model_step(input int i);
        if (rst[i]) begin
            m_pend[i] = 0; m_resp[i] = 0;
            e_ready[i] = 0; e_err[i] = 0; e_busy[i] = 0;
            e_rd[i] = 32'h0; e_known[i] = 1;
        end else if (m_resp[i]) begin
            m_resp[i] = 0; e_ready[i] = 0; e_err[i] = 0; e_busy[i] = 0;
        end else if (m_pend[i]) begin
            if (cyc == m_due[i]) begin
                model_access(i);
                m_pend[i] = 0; m_resp[i] = 1; e_ready[i] = 1;
            end
        end else if (req[i]) begin
            m_pend[i] = 1; m_due[i] = cyc + lat_of(i); e_busy[i] = 1;
            m_we[i] = we[i]; m_be[i] = be[i]; m_addr[i] = addr[i]; m_wd[i] = wd[i];
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            e_known[i] = 0; m_pend[i] = 0; m_resp[i] = 0;
            for (int w = 0; w < DEPTH; w++) m_val[i][w] = 0;
        end
    end

    // ---- per-cycle compare, just after each rising edge ----
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            chk("ready", i, 32'(ready[i]), 32'(e_ready[i]));
            chk("err",   i, 32'(err[i]),   32'(e_err[i]));
            chk("busy",  i, 32'(busy[i]),  32'(e_busy[i]));
            if (e_known[i]) chk("rd", i, rd[i], e_rd[i]);
        end
    end

    task automatic wait_idle(input int i);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (!busy[i]) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout[inst %0d]: busy still %b after 50 cycles, expected 0", i, busy[i]);
        end
    endtask

    task automatic drive(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d);
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wd[i] = d;
    endtask

    task automatic xact(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd_v, output logic err_v,
                        output int lat);
        bit got = 0;
        wait_idle(i);
        @(negedge clk);
        drive(i, w, b, a, d);
        lat = 0; rd_v = 32'h0; err_v = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (ready[i]) begin got = 1; rd_v = rd[i]; err_v = err[i]; break; end
        end
        @(negedge clk);
        req[i] = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ready_timeout[inst %0d]: ready %b after 40 cycles, expected 1", i, ready[i]);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
        else if (r == 7) return 32'hFFC | 32'($urandom_range(0, 3));
        else if (r == 8) return 32'h1000 + 32'($urandom_range(0, 255));
        else             return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat, r1, r2, n;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; drive(i, 1'b1, 4'hF, 32'h10, 32'hBAD0BAD0);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("rst_ready", i, 32'(ready[i]), 32'h0);
                chk("rst_busy",  i, 32'(busy[i]),  32'h0);
                chk("rst_err",   i, 32'(err[i]),   32'h0);
                chk("rst_rd",    i, rd[i],         32'h0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin rst[i] = 1'b0; req[i] = 1'b0; end

        // LATENCY=1: one stall cycle, then ready in the second request cycle
        xact(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r, e, lat);
        chk("l1_store_lat", 0, 32'(lat), 32'd2);
        chk("l1_store_err", 0, 32'(e), 32'h0);
        xact(0, 1'b0, 4'h0, 32'h10, 32'h0, r, e, lat);
        chk("l1_load_rd", 0, r, 32'hDEADBEEF);
        chk("l1_load_lat", 0, 32'(lat), 32'd2);
        xact(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, r, e, lat);
        xact(0, 1'b0, 4'h0, 32'h10, 32'h0, r, e, lat);
        chk("lane_rd", 0, r, 32'hDEADAAEF);
        xact(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, r, e, lat);
        xact(0, 1'b0, 4'h0, 32'h10, 32'h0, r, e, lat);
        chk("be0_rd", 0, r, 32'hDEADAAEF);

        // Out-of-range accesses
        xact(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, r, e, lat);
        xact(0, 1'b1, 4'hF, 32'h1000, 32'h12345678, r, e, lat);
        chk("oor_store_err", 0, 32'(e), 32'h1);
        xact(0, 1'b0, 4'h0, 32'h0, 32'h0, r, e, lat);
        chk("word0_rd", 0, r, 32'hCAFEF00D);
        xact(0, 1'b0, 4'h0, 32'h1000, 32'h0, r, e, lat);
        chk("oor_load_rd", 0, r, 32'h0);
        chk("oor_load_err", 0, 32'(e), 32'h1);
        xact(0, 1'b0, 4'h0, 32'hFFC, 32'h0, r, e, lat);
        chk("last_word_err", 0, 32'(e), 32'h0);

        // LATENCY=3
        xact(1, 1'b1, 4'hF, 32'h10, 32'hDEADAAEF, r, e, lat);
        chk("l3_store_lat", 1, 32'(lat), 32'd4);
        wait_idle(1);
        @(negedge clk);
        drive(1, 1'b0, 4'h0, 32'h10, 32'h0);
        r1 = 0; r2 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ready[1]) begin
                if (r1 == 0) r1 = k; else if (r2 == 0) r2 = k;
                chk("held_rd", 1, rd[1], 32'hDEADAAEF);
            end
        end
        @(negedge clk);
        req[1] = 1'b0;
        chk("held_first_ready", 1, 32'(r1), 32'd4);
        chk("held_gap", 1, 32'(r2 - r1), 32'(LAT1 + 2));

        // Reset pulse while waiting aborts the store
        wait_idle(1);
        @(negedge clk);
        drive(1, 1'b1, 4'hF, 32'h10, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0; req[1] = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready[1]) n++;
        end
        chk("abort_no_ready", 1, 32'(n), 32'h0);
        xact(1, 1'b0, 4'h0, 32'h10, 32'h0, r, e, lat);
        chk("abort_rd", 1, r, 32'hDEADAAEF);
        chk("abort_lat", 1, 32'(lat), 32'd4);

        // Random traffic, including dropped requests and reset pulses
        for (int t = 0; t < 240; t++) begin
            int i    = t % 2;
            int mode = $urandom_range(0, 11);
            if (mode < 10) begin
                xact(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(),
                     $urandom, r, e, lat);
            end else if (mode == 10) begin
                wait_idle(i);
                @(negedge clk);
                drive(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
                @(posedge clk);
                @(negedge clk);
                req[i] = 1'b0;
                n = 0;
                for (int k = 0; k < lat_of(i) + 3; k++) begin
                    @(posedge clk); #1;
                    if (ready[i]) n++;
                end
                chk("drop_ready_count", i, 32'(n), 32'h1);
            end else begin
                wait_idle(i);
                @(negedge clk);
                drive(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                @(negedge clk);
                rst[i] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst[i] = 1'b0; req[i] = 1'b0;
            end
        end

        repeat (4) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
